// File: rtl/mips_perf_counters.sv
// Per-class retired-instruction, stall-cycle and illegal-opcode counters for the MIPS-lite core,
// with halt freeze, sticky overflow flags and an atomic snapshot / read-and-clear bank.
module mips_perf_counters #(
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned SATURATE  = 0,
   parameter int unsigned NUM_CH    = 7,
   localparam int unsigned SEL_W    = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 retire_valid,
   input  logic [5:0]           retire_opcode,
   input  logic                 stall,
   input  logic                 count_en,
   input  logic                 clear,
   input  logic                 snap_req,
   input  logic [SEL_W-1:0]     rd_sel,
   output logic [CNT_WIDTH-1:0] rd_data,
   output logic                 rd_ovf,
   output logic                 halted,
   output logic                 snap_valid
);

   localparam int unsigned ChTotal   = 0;
   localparam int unsigned ChArith   = 1;
   localparam int unsigned ChLogic   = 2;
   localparam int unsigned ChMem     = 3;
   localparam int unsigned ChBranch  = 4;
   localparam int unsigned ChStall   = 5;
   localparam int unsigned ChIllegal = 6;

   localparam logic [5:0] OpArithLast  = 6'h05;
   localparam logic [5:0] OpLogicLast  = 6'h0b;
   localparam logic [5:0] OpMemLast    = 6'h0d;
   localparam logic [5:0] OpBranchLast = 6'h10;
   localparam logic [5:0] OpHalt       = 6'h11;

   if (NUM_CH != 7) begin : g_bad_num_ch
      $error("mips_perf_counters: NUM_CH must be 7 (got %0d)", NUM_CH);
   end
   if (CNT_WIDTH < 8 || CNT_WIDTH > 64) begin : g_bad_cnt_width
      $error("mips_perf_counters: CNT_WIDTH must be in 8..64 (got %0d)", CNT_WIDTH);
   end
   if (SATURATE > 1) begin : g_bad_saturate
      $error("mips_perf_counters: SATURATE must be 0 or 1 (got %0d)", SATURATE);
   end

   // Class channel hit for a retiring opcode; HALT belongs to no class, only to the total.
   function automatic logic [NUM_CH-1:0] class_hit(input logic [5:0] op);
      logic [NUM_CH-1:0] hit;
      hit = '0;
      if (op <= OpArithLast) begin
         hit[ChArith] = 1'b1;
      end else if (op <= OpLogicLast) begin
         hit[ChLogic] = 1'b1;
      end else if (op <= OpMemLast) begin
         hit[ChMem] = 1'b1;
      end else if (op <= OpBranchLast) begin
         hit[ChBranch] = 1'b1;
      end else if (op != OpHalt) begin
         hit[ChIllegal] = 1'b1;
      end
      return hit;
   endfunction

   logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
   logic [CNT_WIDTH-1:0] snap_q [NUM_CH];
   logic [NUM_CH-1:0]    ovf_q;
   logic [NUM_CH-1:0]    ovf_d;
   logic                 halted_q;
   logic                 halted_d;
   logic                 snap_valid_q;

   logic                 act;
   logic                 halt_hit;
   logic [NUM_CH-1:0]    inc;

   always_comb begin
      act      = count_en & ~halted_q;
      inc      = '0;
      halt_hit = 1'b0;
      if (act && retire_valid) begin
         inc          = class_hit(retire_opcode);
         inc[ChTotal] = 1'b1;
         halt_hit     = (retire_opcode == OpHalt);
      end
      if (act && stall) begin
         inc[ChStall] = 1'b1;
      end
   end

   // Clear takes priority over any increment sampled in the same cycle.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         ovf_d[i] = ovf_q[i];
         if (clear) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b0;
         end else if (inc[i]) begin
            if (&cnt_q[i]) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
         end
      end
      halted_d = clear ? 1'b0 : (halted_q | halt_hit);
   end

   // The bank always takes the pre-edge live values, which makes snap_req + clear a read-and-clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
         ovf_q        <= '0;
         halted_q     <= 1'b0;
         snap_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         ovf_q    <= ovf_d;
         halted_q <= halted_d;
         if (snap_req) begin
            for (int i = 0; i < NUM_CH; i++) begin
               snap_q[i] <= cnt_q[i];
            end
            snap_valid_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      rd_ovf  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            rd_data = snap_q[i];
            rd_ovf  = ovf_q[i];
         end
      end
   end

   assign halted     = halted_q;
   assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_mips_perf_counters.sv
// Bench for mips_perf_counters: three instances (32-bit wrap, 8-bit wrap, 8-bit saturate) share
// stimulus; an unbounded-tally model feeds a scoreboard drained by a snapshot monitor.
`timescale 1ns/100ps
module tb_mips_perf_counters;

   localparam int unsigned NCH = 7;
   localparam int unsigned SW  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          retire_valid = 1'b0;
   logic [5:0]    retire_opcode = '0;
   logic          stall = 1'b0;
   logic          count_en = 1'b0;
   logic          clear = 1'b0;
   logic          snap_req = 1'b0;
   logic [SW-1:0] rd_sel = '0;

   logic [31:0] rd_data_a;
   logic [7:0]  rd_data_w;
   logic [7:0]  rd_data_s;
   logic        rd_ovf_a, rd_ovf_w, rd_ovf_s;
   logic        halted_a, halted_w, halted_s;
   logic        sv_a, sv_w, sv_s;

   mips_perf_counters #(.CNT_WIDTH(32), .SATURATE(0), .NUM_CH(7)) dut_a (
      .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_opcode(retire_opcode),
      .stall(stall), .count_en(count_en), .clear(clear), .snap_req(snap_req), .rd_sel(rd_sel),
      .rd_data(rd_data_a), .rd_ovf(rd_ovf_a), .halted(halted_a), .snap_valid(sv_a)
   );

   mips_perf_counters #(.CNT_WIDTH(8), .SATURATE(0), .NUM_CH(7)) dut_w (
      .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_opcode(retire_opcode),
      .stall(stall), .count_en(count_en), .clear(clear), .snap_req(snap_req), .rd_sel(rd_sel),
      .rd_data(rd_data_w), .rd_ovf(rd_ovf_w), .halted(halted_w), .snap_valid(sv_w)
   );

   mips_perf_counters #(.CNT_WIDTH(8), .SATURATE(1), .NUM_CH(7)) dut_s (
      .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_opcode(retire_opcode),
      .stall(stall), .count_en(count_en), .clear(clear), .snap_req(snap_req), .rd_sel(rd_sel),
      .rd_data(rd_data_s), .rd_ovf(rd_ovf_s), .halted(halted_s), .snap_valid(sv_s)
   );

   always #5 clk = ~clk;

   // Model: unbounded event tallies since the last clear/reset; width effects derived on compare.
   logic [63:0] tally [NCH];
   bit          halted_m;

   typedef struct packed {
      logic [NCH-1:0][63:0] pre;
      logic [NCH-1:0][63:0] post;
      logic                 halted;
   } rec_t;

   rec_t sb_q [$];
   int   errors = 0;
   int   checks = 0;
   logic snap_seen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_val(input logic [63:0] t, input int w, input bit sat);
      logic [63:0] lim;
      lim = 64'd1 << w;
      if (t < lim) return t;
      return sat ? lim - 64'd1 : t % lim;
   endfunction

   function automatic logic exp_ovf(input logic [63:0] t, input int w);
      logic [63:0] lim;
      lim = 64'd1 << w;
      return t >= lim;
   endfunction

   // 0 means "no class channel" (HALT).
   function automatic int op_class(input logic [5:0] op);
      if (op <= 6'h05) return 1;
      if (op <= 6'h0b) return 2;
      if (op <= 6'h0d) return 3;
      if (op <= 6'h10) return 4;
      if (op == 6'h11) return 0;
      return 6;
   endfunction

   task automatic model_step(input bit rv, input logic [5:0] op, input bit st, input bit en,
                             input bit clr);
      bit act;
      int c;
      act = en && !halted_m;
      if (clr) begin
         for (int i = 0; i < NCH; i++) tally[i] = '0;
         halted_m = 1'b0;
      end else begin
         if (act && rv) begin
            tally[0]++;
            c = op_class(op);
            if (c != 0) tally[c]++;
            else halted_m = 1'b1;
         end
         if (act && st) tally[5]++;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) tally[i] = '0;
      halted_m = 1'b0;
   endtask

   // Drive one cycle's inputs at posedge+1, advance the model, queue any snapshot expectation.
   task automatic cycle(input bit rv, input logic [5:0] op, input bit st, input bit en,
                        input bit clr, input bit snp);
      rec_t r;
      retire_valid  = rv;
      retire_opcode = op;
      stall         = st;
      count_en      = en;
      clear         = clr;
      snap_req      = snp;
      for (int i = 0; i < NCH; i++) r.pre[i] = tally[i];
      model_step(rv, op, st, en, clr);
      if (snp) begin
         for (int i = 0; i < NCH; i++) r.post[i] = tally[i];
         r.halted = halted_m;
         sb_q.push_back(r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      retire_valid = 1'b0;
      retire_opcode = '0;
      stall = 1'b0;
      count_en = 1'b0;
      clear = 1'b0;
      snap_req = 1'b0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) snap_seen <= 1'b0;
      else snap_seen <= snap_req;
   end

   // Monitor: after each snapshot edge, sweep rd_sel within the low clock phase and compare.
   initial begin : monitor
      rec_t r;
      forever begin
         @(negedge clk);
         if (snap_seen) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               r = sb_q.pop_front();
               for (int s = 0; s < 8; s++) begin
                  rd_sel = SW'(s);
                  #0.5;
                  if (s < NCH) begin
                     chk($sformatf("ch%0d_data_w32", s), 64'(rd_data_a), exp_val(r.pre[s], 32, 0));
                     chk($sformatf("ch%0d_data_w8", s), 64'(rd_data_w), exp_val(r.pre[s], 8, 0));
                     chk($sformatf("ch%0d_data_s8", s), 64'(rd_data_s), exp_val(r.pre[s], 8, 1));
                     chk($sformatf("ch%0d_ovf_w32", s), 64'(rd_ovf_a), 64'(exp_ovf(r.post[s], 32)));
                     chk($sformatf("ch%0d_ovf_w8", s), 64'(rd_ovf_w), 64'(exp_ovf(r.post[s], 8)));
                     chk($sformatf("ch%0d_ovf_s8", s), 64'(rd_ovf_s), 64'(exp_ovf(r.post[s], 8)));
                  end else begin
                     chk("sel7_data", {rd_data_a, rd_data_w, rd_data_s}, 64'd0);
                     chk("sel7_ovf", {61'd0, rd_ovf_a, rd_ovf_w, rd_ovf_s}, 64'd0);
                  end
               end
               chk("snap_halted", {61'd0, halted_a, halted_w, halted_s}, {61'd0, {3{r.halted}}});
               chk("snap_valid", {61'd0, sv_a, sv_w, sv_s}, 64'd7);
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, {rd_data_a, rd_data_w, rd_data_s}, 64'd0);
      chk({tag, "_ovf"}, {61'd0, rd_ovf_a, rd_ovf_w, rd_ovf_s}, 64'd0);
      chk({tag, "_halted"}, {61'd0, halted_a, halted_w, halted_s}, 64'd0);
      chk({tag, "_snap_valid"}, {61'd0, sv_a, sv_w, sv_s}, 64'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      model_reset();
      #1;
      for (int s = 0; s < 8; s++) begin
         rd_sel = SW'(s);
         #0.1;
         chk_all_zero("reset");
      end
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Mixed classes including an illegal opcode.
      cycle(1, 6'h00, 0, 1, 0, 0);
      cycle(1, 6'h07, 0, 1, 0, 0);
      cycle(1, 6'h0c, 0, 1, 0, 0);
      cycle(1, 6'h0f, 0, 1, 0, 0);
      cycle(1, 6'h3f, 0, 1, 0, 0);
      cycle(0, 6'h00, 0, 1, 0, 1);

      // Stall with concurrent retires.
      cycle(0, 6'h00, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) cycle(i < 4, 6'h01, 1, 1, 0, 0);
      cycle(0, 6'h00, 0, 1, 0, 1);

      // HALT freezes everything, including stall counting.
      cycle(0, 6'h00, 0, 1, 1, 0);
      cycle(1, 6'h11, 0, 1, 0, 0);
      chk("halted_after_halt", {61'd0, halted_a, halted_w, halted_s}, {61'd0, {3{halted_m}}});
      for (int i = 0; i < 3; i++) cycle(1, 6'h00, i < 2, 1, 0, 0);
      cycle(0, 6'h00, 0, 1, 0, 1);
      cycle(0, 6'h00, 0, 1, 1, 0);
      chk("halted_after_clear", {61'd0, halted_a, halted_w, halted_s}, 64'd0);

      // 8-bit overflow: wrap vs saturate.
      for (int i = 0; i < 257; i++) cycle(1, 6'h02, 0, 1, 0, 0);
      cycle(0, 6'h00, 0, 1, 0, 1);

      // Atomic read-and-clear, then a second snapshot shows the zeroed live bank.
      cycle(0, 6'h00, 0, 1, 1, 0);
      for (int i = 0; i < 20; i++) cycle(1, 6'h00, 0, 1, 0, 0);
      cycle(1, 6'h00, 0, 1, 1, 1);
      cycle(0, 6'h00, 0, 1, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 9) < 7, 6'($urandom_range(0, 63)), $urandom_range(0, 9) < 3,
               $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0);
      end

      // Asynchronous reset mid-count, checked before the next clock edge.
      cycle(0, 6'h00, 0, 1, 1, 1);
      for (int i = 0; i < 9; i++) cycle(1, 6'h00, 0, 1, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      idle_inputs();
      #1;
      chk_all_zero("async_reset");
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1, 6'h0c, 1, 1, 0, 0);
      cycle(0, 6'h00, 0, 1, 0, 1);

      cycle(0, 6'h00, 0, 0, 0, 0);
      cycle(0, 6'h00, 0, 0, 0, 0);
      chk("sb_drain", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_perf_counters.md
Name: mips_perf_counters

Overview:
- Hardware successor to the MIPS-lite simulator's software instruction tallies (total/arithmetic/logical/memory/branch).
- Sits beside the WB stage and counts retired instructions by class, plus stall cycles and illegal opcodes.
- Counter width and wrap/saturate mode are parameters.
- Adds halt-freeze, sticky overflow, and an atomic snapshot / read-and-clear bank for the testbench or debug port.

Parameters:
- CNT_WIDTH, 32: width of each counter, legal range 8..64.
- SATURATE, 0: 0 = counters wrap to 0 on overflow; 1 = counters hold at all-ones.
- NUM_CH, 7: channel count, fixed by the class map below. Any other value is illegal and must trigger an elaboration-time error.
- SEL_W, $clog2(NUM_CH): width of rd_sel (localparam).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- retire_valid  in  1  one instruction retires this cycle
- retire_opcode  in  6  opcode of the retiring instruction
- stall  in  1  pipeline stalled this cycle
- count_en  in  1  global count enable
- clear  in  1  synchronous clear of live counters, overflow flags and halted
- snap_req  in  1  copy all live counters into the snapshot bank
- rd_sel  in  SEL_W  snapshot channel select
- rd_data  out  CNT_WIDTH  snapshot value of channel rd_sel (combinational mux)
- rd_ovf  out  1  sticky overflow flag of channel rd_sel (live)
- halted  out  1  HALT retired; counting frozen
- snap_valid  out  1  snapshot bank holds data since the last reset

Behaviour:
- Channel map:
  - 0 = total retired
  - 1 = arithmetic (opcodes 0x00-0x05)
  - 2 = logical (0x06-0x0B)
  - 3 = memory (0x0C-0x0D)
  - 4 = branch/jump (0x0E-0x10)
  - 5 = stall cycles
  - 6 = illegal (0x12-0x3F)
- HALT (0x11) increments ch0 only.
- ch0 increments on every retire, including illegal opcodes.
- Increment gating: act = count_en & ~halted.
  - On a rising edge with act = 1 and retire_valid = 1: ch0 and the matching class channel each increment by 1.
  - Independently, with act = 1 and stall = 1: ch5 increments by 1.
  - retire_valid and stall together are legal; both sets of increments occur.
- Latency: an increment is visible in the live counter 1 cycle after the sampling edge, and in rd_data only after a later snap_req.
- Overflow, applied per channel when incrementing from all-ones:
  - SATURATE = 0: counter becomes 0 and its ovf flag is set.
  - SATURATE = 1: counter stays all-ones and its ovf flag is set.
  - ovf is sticky until clear or reset.
- Halt: when HALT is retired with act = 1, halted is set at that edge, and ch0 still counts the HALT.
  - While halted, no channel increments, including stall.
  - halted is cleared only by clear or reset.
- Snapshot: when snap_req = 1 at an edge, the bank captures the live values as they were before that edge's increments. snap_valid is set to 1.
  - The bank holds its contents until the next snap_req.
- Clear: when clear = 1 at an edge, all live counters, ovf flags and halted go to 0. Increments in the same cycle are discarded (clear wins).
- snap_req and clear in the same cycle: the bank receives the pre-clear values, then the live counters are zeroed (atomic read-and-clear).
- rd_sel out of range (7 when SEL_W = 3): rd_data = 0, rd_ovf = 0.
- Reset (asynchronous, active-low), effective immediately, including mid-count:
  - all live counters, snapshot registers, ovf flags, halted and snap_valid go to 0;
  - consequently rd_data = 0 and rd_ovf = 0.
- No X on any output after reset, regardless of the X-state of the inputs.

Test Plan:
- Reset, then retire opcodes 0x00, 0x07, 0x0C, 0x0F, 0x3F with count_en = 1, then snap_req -> snapshot ch0 = 5, ch1 = 1, ch2 = 1, ch3 = 1, ch4 = 1, ch6 = 1, ch5 = 0.
- Hold stall = 1 for 10 cycles while retiring 0x01 on 4 of those cycles, then snap_req -> ch5 = 10, ch1 = 4, ch0 = 4.
- Retire 0x11, then 3 more retires of 0x00 plus 2 stall cycles -> halted = 1 one cycle after HALT. Snapshot ch0 = 1, all other channels 0. Then clear -> halted = 0.
- CNT_WIDTH = 8, SATURATE = 0, 257 retires of 0x02 -> ch1 = 1 and rd_ovf = 1 for ch1. Repeat with SATURATE = 1 -> ch1 = 255 and rd_ovf = 1.
- Live ch0 = 20, then snap_req, clear and a retire of 0x00 all in the same cycle -> snapshot ch0 = 20; live ch0 = 0 (shown by a second snap_req one cycle later returning ch0 = 0).
- Deassert rst_n asynchronously mid-count (between clock edges) with ch0 = 9 -> rd_data = 0, halted = 0 and snap_valid = 0 before the next clock edge.
